// File: rtl/usb_rx_nrzi_unstuff_if.sv
// Bit-level receive bus between the USB line sampler and the NRZI/unstuff front end.
// The master side drives the line and the strobes; the slave side returns the assembled words and error flags.
interface usb_rx_nrzi_unstuff_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  dplus_sync;
    logic                  shift_enable;
    logic                  eop;
    logic                  rx_clear;
    logic                  d_bit;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  stuff_err;
    logic                  align_err;

    modport master (
        output dplus_sync, shift_enable, eop, rx_clear,
        input  d_bit, rx_data, rx_valid, stuff_err, align_err
    );

    modport slave (
        input  dplus_sync, shift_enable, eop, rx_clear,
        output d_bit, rx_data, rx_valid, stuff_err, align_err
    );
endinterface

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive front end: NRZI decode, bit-unstuffing, and LSB-first word assembly.
// It flags bit-stuff violations and packets that end partway through a word.
module usb_rx_nrzi_unstuff #(
    parameter int   DATA_WIDTH = 8,
    parameter int   STUFF_LEN  = 6,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    usb_rx_nrzi_unstuff_if.slave bus
);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_ERROR
    } state_t;

    state_t                state;
    logic                  prev_level;
    logic                  d_bit_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  stuff_err_q;
    logic                  align_err_q;
    logic [OW-1:0]         ones_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  dec_bit;
    logic [DATA_WIDTH-1:0] next_word;

    // A level that matches the previous one decodes to 1; a transition decodes to 0.
    assign dec_bit   = ~(bus.dplus_sync ^ prev_level);
    assign next_word = {dec_bit, shreg[DATA_WIDTH-1:1]};

    assign bus.d_bit     = d_bit_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.stuff_err = stuff_err_q;
    assign bus.align_err = align_err_q;

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below sees the pre-edge values of the counters and the shift register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            prev_level  <= IDLE_LEVEL;
            d_bit_q     <= 1'b1;
            shreg       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            stuff_err_q <= 1'b0;
            align_err_q <= 1'b0;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
        end else begin
            rx_valid_q <= 1'b0;

            if (bus.shift_enable) begin
                if (bus.eop) begin
                    prev_level <= IDLE_LEVEL;
                    d_bit_q    <= 1'b1;
                end else begin
                    prev_level <= bus.dplus_sync;
                    d_bit_q    <= dec_bit;
                end
            end

            if (bus.rx_clear) begin
                state       <= ST_RECV;
                ones_cnt    <= '0;
                bit_cnt     <= '0;
                shreg       <= '0;
                stuff_err_q <= 1'b0;
                align_err_q <= 1'b0;
            end else if (bus.shift_enable && bus.eop) begin
                case (state)
                    ST_RECV: begin
                        if (bit_cnt != '0) align_err_q <= 1'b1;
                        state    <= ST_IDLE;
                        ones_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                    ST_ERROR: state <= ST_IDLE;
                    default:  state <= state;
                endcase
            end else if (bus.shift_enable && state == ST_RECV) begin
                if (ones_cnt == OW'(STUFF_LEN)) begin
                    // After a full run of ones the next bit must be the stuffed 0.
                    if (dec_bit) begin
                        stuff_err_q <= 1'b1;
                        state       <= ST_ERROR;
                    end else begin
                        ones_cnt <= '0;
                    end
                end else begin
                    shreg    <= next_word;
                    ones_cnt <= dec_bit ? ones_cnt + OW'(1) : '0;
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        rx_data_q  <= next_word;
                        rx_valid_q <= 1'b1;
                        bit_cnt    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: doc/usb_rx_nrzi_unstuff.md
Name: usb_rx_nrzi_unstuff

Overview:
Parametrised USB receive-path front end. It NRZI-decodes the synchronised D+ line on each bit strobe, removes stuffed bits after STUFF_LEN consecutive ones, and assembles the unstuffed bits LSB-first into DATA_WIDTH-bit words. It sits between the edge/EOP detectors and the receive byte FIFO/controller, and flags bit-stuff and byte-alignment errors.

Parameters:
DATA_WIDTH, 8, assembled word width; legal range 2 or more.
STUFF_LEN, 6, number of consecutive decoded ones after which a stuffed 0 is expected; legal range 1 or more.
IDLE_LEVEL, 1, line level of idle/J state; reloaded into the previous-level register at reset and at EOP.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
dplus_sync  input  1  synchronised D+ line level
shift_enable  input  1  one-cycle bit strobe at the sample point
eop  input  1  end-of-packet indication; acted on only when shift_enable=1
rx_clear  input  1  synchronous start-of-packet clear; enters RECV
d_bit  output  1  registered most recent decoded NRZI bit
rx_data  output  DATA_WIDTH  last completed word, LSB = first received bit
rx_valid  output  1  one-cycle pulse, new rx_data available
stuff_err  output  1  sticky bit-stuff violation flag
align_err  output  1  sticky flag, EOP arrived mid-word

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on n_rst.
- Reset values: prev_level=IDLE_LEVEL, d_bit=1, state=IDLE, rx_data=0, rx_valid=0, stuff_err=0, align_err=0, ones_cnt=0, bit_cnt=0, shift register=0.
- NRZI decode, in every state, when shift_enable=1 and eop=0:
  - decoded bit b = ~(dplus_sync ^ prev_level).
  - prev_level <= dplus_sync.
  - d_bit <= b.
- When shift_enable=1 and eop=1: no bit is decoded; prev_level <= IDLE_LEVEL; d_bit <= 1.
- When shift_enable=0, nothing changes except the rx_valid deassert.
- States: IDLE, RECV, ERROR.
- Priority: rx_clear > (shift_enable&eop) > bit processing.
- rx_clear, any state:
  - state <= RECV.
  - ones_cnt, bit_cnt, shift register <= 0.
  - stuff_err, align_err <= 0.
  - prev_level is unaffected; NRZI decoding of a strobe in the same cycle still occurs, but that bit is not shifted.
- IDLE: bits are decoded but not shifted. eop has no state effect.
- RECV, per decoded bit b:
  - ones_cnt==STUFF_LEN and b=0: stuffed bit. It is discarded; ones_cnt <= 0; bit_cnt is unchanged.
  - ones_cnt==STUFF_LEN and b=1: stuff_err <= 1; state <= ERROR; the bit is discarded.
  - Otherwise: b is shifted in at the MSB with a right shift; ones_cnt <= b ? ones_cnt+1 : 0; bit_cnt <= bit_cnt+1.
  - When the accepted bit is the DATA_WIDTH-th: rx_data <= the completed word and rx_valid=1 in the next cycle only. bit_cnt wraps to 0. ones_cnt carries across word boundaries.
- RECV, on shift_enable&eop:
  - If bit_cnt!=0, align_err <= 1.
  - The partial word is discarded and rx_data is unchanged.
  - state <= IDLE; ones_cnt, bit_cnt <= 0.
- ERROR: decoded bits are ignored for shifting. On shift_enable&eop, state <= IDLE and stuff_err stays 1.
- Error flags clear only on rx_clear or reset.
- Latency: rx_valid rises 1 clk after the strobe that accepted the final bit. rx_data holds until the next rx_valid.
- Counter widths: ones_cnt is $clog2(STUFF_LEN+1) bits; bit_cnt is $clog2(DATA_WIDTH) bits.
- Reset asserted mid-word: immediate return to reset values; no rx_valid.

Test Plan:
1. Reset with n_rst=0, then release and idle 20 clks with no strobes -> d_bit=1, rx_data=0x00, rx_valid=0, stuff_err=0, align_err=0 throughout.
2. rx_clear, then 8 strobes with line levels 0,1,0,1,0,1,0,0 (SYNC 0x80 from prev=1) -> rx_data=0x80, rx_valid high exactly 1 clk after the 8th strobe, d_bit=1.
3. rx_clear, then 6 ones (line held), a stuffed 0 (toggle), then 2 ones (held) -> rx_data=0xFF after the 9th strobe, one rx_valid pulse, stuff_err=0.
4. rx_clear, then 7 consecutive ones -> stuff_err=1 one clk after the 7th strobe, state ERROR, no rx_valid. Further strobes leave rx_data unchanged. eop strobe -> IDLE with stuff_err=1. rx_clear -> stuff_err=0.
5. rx_clear, 3 data bits, then a strobe with eop=1 -> align_err=1, no rx_valid, rx_data unchanged. Next decoded bit uses prev_level=1.
6. rx_clear and eop strobe in the same cycle -> state RECV, counters 0, align_err=0. Separately, n_rst pulsed after 5 bits of a word -> all reset values and no rx_valid afterwards.
